// File: rtl/decode_stage_if.sv
// Bundle between decode_stage and its pipeline neighbours (fetch, WB, EX/MEM, ID/EX consumers).
// ID_ILLEGAL_DETECT_EN adds the illegal_instr signal.
interface decode_stage_if;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic        load_pc;
  logic        load_if_id_register;
  logic        mux_sel;
  logic [31:0] pc_branch_value;
  logic        if_flush;
  logic [31:0] idex_pc;
  logic [31:0] idex_rs1_data;
  logic [31:0] idex_rs2_data;
  logic [31:0] idex_imm;
  logic [4:0]  idex_rs1;
  logic [4:0]  idex_rs2;
  logic [4:0]  idex_rd;
  logic [4:0]  idex_ctrl;
  logic [3:0]  idex_alu_ctrl;
`ifdef ID_ILLEGAL_DETECT_EN
  logic        illegal_instr;

  modport master (
    output ifid_pc, ifid_instr, wb_reg_write, wb_rd, wb_data, exmem_reg_write, exmem_rd,
    input  load_pc, load_if_id_register, mux_sel, pc_branch_value, if_flush,
    input  idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1, idex_rs2, idex_rd,
    input  idex_ctrl, idex_alu_ctrl, illegal_instr
  );
  modport slave (
    input  ifid_pc, ifid_instr, wb_reg_write, wb_rd, wb_data, exmem_reg_write, exmem_rd,
    output load_pc, load_if_id_register, mux_sel, pc_branch_value, if_flush,
    output idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1, idex_rs2, idex_rd,
    output idex_ctrl, idex_alu_ctrl, illegal_instr
  );
`else
  modport master (
    output ifid_pc, ifid_instr, wb_reg_write, wb_rd, wb_data, exmem_reg_write, exmem_rd,
    input  load_pc, load_if_id_register, mux_sel, pc_branch_value, if_flush,
    input  idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1, idex_rs2, idex_rd,
    input  idex_ctrl, idex_alu_ctrl
  );
  modport slave (
    input  ifid_pc, ifid_instr, wb_reg_write, wb_rd, wb_data, exmem_reg_write, exmem_rd,
    output load_pc, load_if_id_register, mux_sel, pc_branch_value, if_flush,
    output idex_pc, idex_rs1_data, idex_rs2_data, idex_imm, idex_rs1, idex_rs2, idex_rd,
    output idex_ctrl, idex_alu_ctrl
  );
`endif
endinterface

// File: rtl/decode_stage.sv
// ID stage: register file, immediate/control decode, load-use and branch hazards, BEQ/BNE resolution.
// Optional macro ID_ILLEGAL_DETECT_EN adds a registered illegal-opcode flag.
module decode_stage #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RF_RESET_VAL = '0
) (
  input logic          clock,
  input logic          reset,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [XLEN-1:0] rf [0:31];

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [2:0]  f3;
  logic        f7b5;

  assign instr  = bus.ifid_instr;
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign f7b5   = instr[30];

  logic signed [XLEN-1:0] imm_i, imm_s, imm_b;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  logic [XLEN-1:0] rs1_data, rs2_data;

  // Write-through read so a WB in the same cycle is seen by the instruction in ID.
  always_comb begin
    if (rs1_f == 5'd0)                           rs1_data = '0;
    else if (bus.wb_reg_write && bus.wb_rd == rs1_f) rs1_data = bus.wb_data;
    else                                         rs1_data = rf[rs1_f];
    if (rs2_f == 5'd0)                           rs2_data = '0;
    else if (bus.wb_reg_write && bus.wb_rd == rs2_f) rs2_data = bus.wb_data;
    else                                         rs2_data = rf[rs2_f];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? '0 : RF_RESET_VAL;
    end else if (bus.wb_reg_write && bus.wb_rd != 5'd0) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  logic [4:0]             ctrl_p0;
  logic [3:0]             alu_p0;
  logic [4:0]             rd_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   uses_rs1, uses_rs2, is_branch;

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src}; branches decode to a bubble.
  always_comb begin
    ctrl_p0   = '0;
    alu_p0    = '0;
    rd_p0     = '0;
    imm_p0    = imm_i;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_p0 = 5'b10000; alu_p0 = {f7b5, f3}; rd_p0 = rd_f;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_I: begin
        ctrl_p0 = 5'b10001; alu_p0 = {(f3 == 3'b101) & f7b5, f3}; rd_p0 = rd_f;
        uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl_p0 = 5'b11011; rd_p0 = rd_f; uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl_p0 = 5'b00101; imm_p0 = imm_s;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm_p0 = imm_b;
        if (f3 == 3'b000 || f3 == 3'b001) begin
          is_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0]        pc_p1, rs1d_p1, rs2d_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [4:0]             rs1_p1, rs2_p1, rd_p1, ctrl_p1;
  logic [3:0]             alu_p1;

  logic load_use, br_hazard, stall, taken;

  assign load_use = ctrl_p1[3] && (rd_p1 != 5'd0) &&
                    ((uses_rs1 && rs1_f == rd_p1) || (uses_rs2 && rs2_f == rd_p1));

  assign br_hazard = is_branch &&
    ((rs1_f != 5'd0 && ((ctrl_p1[4] && rs1_f == rd_p1) || (bus.exmem_reg_write && rs1_f == bus.exmem_rd))) ||
     (rs2_f != 5'd0 && ((ctrl_p1[4] && rs2_f == rd_p1) || (bus.exmem_reg_write && rs2_f == bus.exmem_rd))));

  assign stall = load_use || br_hazard;
  assign taken = is_branch && !stall && (f3[0] ? (rs1_data != rs2_data) : (rs1_data == rs2_data));

  assign bus.load_pc             = reset || !stall;
  assign bus.load_if_id_register = reset || !stall;
  assign bus.mux_sel             = !reset && taken;
  assign bus.if_flush            = !reset && taken;
  assign bus.pc_branch_value     = bus.ifid_pc + $unsigned(imm_b);

  // ---- ID/EX boundary ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_p1   <= '0; rs1d_p1 <= '0; rs2d_p1 <= '0; imm_p1 <= '0;
      rs1_p1  <= '0; rs2_p1  <= '0; rd_p1   <= '0; ctrl_p1 <= '0; alu_p1 <= '0;
    end else begin
      pc_p1   <= bus.ifid_pc;
      rs1d_p1 <= rs1_data;
      rs2d_p1 <= rs2_data;
      imm_p1  <= imm_p0;
      rs1_p1  <= rs1_f;
      rs2_p1  <= rs2_f;
      rd_p1   <= stall ? 5'd0 : rd_p0;
      ctrl_p1 <= stall ? 5'd0 : ctrl_p0;
      alu_p1  <= stall ? 4'd0 : alu_p0;
    end
  end

  assign bus.idex_pc       = pc_p1;
  assign bus.idex_rs1_data = rs1d_p1;
  assign bus.idex_rs2_data = rs2d_p1;
  assign bus.idex_imm      = imm_p1;
  assign bus.idex_rs1      = rs1_p1;
  assign bus.idex_rs2      = rs2_p1;
  assign bus.idex_rd       = rd_p1;
  assign bus.idex_ctrl     = ctrl_p1;
  assign bus.idex_alu_ctrl = alu_p1;

`ifdef ID_ILLEGAL_DETECT_EN
  logic illegal_p0, illegal_p1;

  // The all-zero word marks a flushed slot and is never reported.
  assign illegal_p0 = (instr != 32'd0) &&
                      !(opcode == OP_R || opcode == OP_I || opcode == OP_LOAD ||
                        opcode == OP_STORE || is_branch);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) illegal_p1 <= 1'b0;
    else       illegal_p1 <= illegal_p0;
  end

  assign bus.illegal_instr = illegal_p1;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage plus hand-written reset sequences.
module tb_decode_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  decode_stage_if bus ();

  decode_stage #(.XLEN(32), .RF_RESET_VAL(32'd0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic        e_load;
    logic        e_mux;
    logic [31:0] e_br;
    logic        chk_br;
    logic [4:0]  e_ctrl;
    logic [3:0]  e_alu;
    logic [4:0]  e_rd;
    logic [31:0] e_rs1d;
    logic [31:0] e_rs2d;
    logic        chk_rs;
    logic [31:0] e_imm;
    logic        chk_imm;
    logic        e_ill;
  } vec_t;

  vec_t vecs [16];
  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                       input logic ex_we, input logic [4:0] ex_rd);
    bus.ifid_instr      = instr;
    bus.ifid_pc         = pc;
    bus.wb_reg_write    = wb_we;
    bus.wb_rd           = wb_rd;
    bus.wb_data         = wb_data;
    bus.exmem_reg_write = ex_we;
    bus.exmem_rd        = ex_rd;
  endtask

  initial begin
    //          instr         pc            wb  rd  data          ex rd   ld mux br            cb ctrl      alu      rd    rs1d          rs2d          cr imm           ci ill
    vecs[0]  = '{32'h00028333, 32'h0,       1, 5,  32'hAA, 0, 0,  1, 0, 32'h0,        0, 5'b10000, 4'b0000, 5'd6,  32'hAA, 32'h0, 1, 32'h0,        0, 0};
    vecs[1]  = '{32'h00000000, 32'h4,       1, 1,  32'h3,  0, 0,  1, 0, 32'h0,        0, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 0};
    vecs[2]  = '{32'hFFF08493, 32'h8,       1, 2,  32'h3,  0, 0,  1, 0, 32'h0,        0, 5'b10001, 4'b0000, 5'd9,  32'h3,  32'h0, 1, 32'hFFFFFFFF, 1, 0};
    vecs[3]  = '{32'h4030D513, 32'hC,       0, 0,  32'h0,  0, 0,  1, 0, 32'h0,        0, 5'b10001, 4'b1101, 5'd10, 32'h3,  32'h0, 1, 32'h00000403, 1, 0};
    vecs[4]  = '{32'h402085B3, 32'h10,      0, 0,  32'h0,  0, 0,  1, 0, 32'h0,        0, 5'b10000, 4'b1000, 5'd11, 32'h3,  32'h3, 1, 32'h0,        0, 0};
    vecs[5]  = '{32'hFE20AE23, 32'h14,      0, 0,  32'h0,  0, 0,  1, 0, 32'h0,        0, 5'b00101, 4'b0000, 5'd0,  32'h3,  32'h3, 1, 32'hFFFFFFFC, 1, 0};
    vecs[6]  = '{32'hFFFFFFFF, 32'h18,      0, 0,  32'h0,  0, 0,  1, 0, 32'h0,        0, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 1};
    vecs[7]  = '{32'h00209463, 32'h200,     0, 0,  32'h0,  0, 0,  1, 0, 32'h208,      1, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 0};
    vecs[8]  = '{32'h00208863, 32'h100,     0, 0,  32'h0,  0, 0,  1, 1, 32'h110,      1, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 0};
    vecs[9]  = '{32'h0020C863, 32'h100,     0, 0,  32'h0,  0, 0,  1, 0, 32'h0,        0, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 1};
    vecs[10] = '{32'h0000A383, 32'h20,      0, 0,  32'h0,  0, 0,  1, 0, 32'h0,        0, 5'b11011, 4'b0000, 5'd7,  32'h3,  32'h0, 1, 32'h0,        1, 0};
    vecs[11] = '{32'h00238433, 32'h24,      0, 0,  32'h0,  0, 0,  0, 0, 32'h0,        0, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 0};
    vecs[12] = '{32'h00238433, 32'h24,      0, 0,  32'h0,  0, 0,  1, 0, 32'h0,        0, 5'b10000, 4'b0000, 5'd8,  32'h0,  32'h3, 1, 32'h0,        0, 0};
    vecs[13] = '{32'hFE018CE3, 32'h4,       0, 0,  32'h0,  1, 3,  0, 0, 32'h0,        0, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 0};
    vecs[14] = '{32'hFE018CE3, 32'h4,       0, 0,  32'h0,  0, 0,  1, 1, 32'hFFFFFFFC, 1, 5'b00000, 4'b0000, 5'd0,  32'h0,  32'h0, 0, 32'h0,        0, 0};
    vecs[15] = '{32'h00000633, 32'h28,      1, 0,  32'h55, 0, 0,  1, 0, 32'h0,        0, 5'b10000, 4'b0000, 5'd12, 32'h0,  32'h0, 1, 32'h0,        0, 0};

    drive(32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
    #1;
    chk("reset_idex_ctrl", {27'd0, bus.idex_ctrl}, 32'h0);
    chk("reset_idex_pc", bus.idex_pc, 32'h0);
    chk("reset_load_pc", {31'd0, bus.load_pc}, 32'h1);
    chk("reset_mux_sel", {31'd0, bus.mux_sel}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clock);
      drive(v.instr, v.pc, v.wb_we, v.wb_rd, v.wb_data, v.ex_we, v.ex_rd);
      #1;
      chk($sformatf("v%0d_load_pc", i), {31'd0, bus.load_pc}, {31'd0, v.e_load});
      chk($sformatf("v%0d_load_ifid", i), {31'd0, bus.load_if_id_register}, {31'd0, v.e_load});
      chk($sformatf("v%0d_mux_sel", i), {31'd0, bus.mux_sel}, {31'd0, v.e_mux});
      chk($sformatf("v%0d_if_flush", i), {31'd0, bus.if_flush}, {31'd0, v.e_mux});
      if (v.chk_br) chk($sformatf("v%0d_br_target", i), bus.pc_branch_value, v.e_br);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_ctrl", i), {27'd0, bus.idex_ctrl}, {27'd0, v.e_ctrl});
      chk($sformatf("v%0d_rd", i), {27'd0, bus.idex_rd}, {27'd0, v.e_rd});
      if (v.e_ctrl != 5'd0) begin
        chk($sformatf("v%0d_alu", i), {28'd0, bus.idex_alu_ctrl}, {28'd0, v.e_alu});
        chk($sformatf("v%0d_pc", i), bus.idex_pc, v.pc);
      end
      if (v.chk_rs) begin
        chk($sformatf("v%0d_rs1d", i), bus.idex_rs1_data, v.e_rs1d);
        chk($sformatf("v%0d_rs2d", i), bus.idex_rs2_data, v.e_rs2d);
      end
      if (v.chk_imm) chk($sformatf("v%0d_imm", i), bus.idex_imm, v.e_imm);
`ifdef ID_ILLEGAL_DETECT_EN
      chk($sformatf("v%0d_illegal", i), {31'd0, bus.illegal_instr}, {31'd0, v.e_ill});
`endif
    end

    // Asynchronous reset mid-cycle while a taken branch (x1 == x2 == 3) sits in ID.
    @(negedge clock);
    drive(32'h00208863, 32'h100, 0, 0, 32'h0, 0, 0);
    #1;
    chk("pre_reset_mux_sel", {31'd0, bus.mux_sel}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_reset_ctrl", {27'd0, bus.idex_ctrl}, 32'h0);
    chk("async_reset_rd", {27'd0, bus.idex_rd}, 32'h0);
    chk("async_reset_pc", bus.idex_pc, 32'h0);
    chk("async_reset_mux_sel", {31'd0, bus.mux_sel}, 32'h0);
    chk("async_reset_if_flush", {31'd0, bus.if_flush}, 32'h0);
    chk("async_reset_load_pc", {31'd0, bus.load_pc}, 32'h1);
    @(negedge clock);
    reset = 1'b0;
    drive(32'h00028333, 32'h0, 0, 0, 32'h0, 0, 0);
    @(posedge clock);
    #1;
    chk("post_reset_x5", bus.idex_rs1_data, 32'h0);
    chk("post_reset_ctrl", {27'd0, bus.idex_ctrl}, 32'h10);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
